// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational 4-bit ALU between two
// valid/ready requesters and returning results over a timed response handshake.
module alu_share_ctrl #(
    parameter int RSP_TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [2:0] i_req0_a,
    input  logic [3:0] i_req0_b,
    input  logic [2:0] i_req0_op,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [2:0] i_req1_a,
    input  logic [3:0] i_req1_b,
    input  logic [2:0] i_req1_op,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic       o_rsp_id,
    output logic [3:0] o_rsp_result,
    output logic       o_rsp_err,
    output logic [2:0] o_alu_a,
    output logic [3:0] o_alu_b,
    output logic [2:0] o_alu_op,
    input  logic [3:0] i_alu_result,
    output logic       o_drop_pulse,
    output logic [7:0] o_op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(RSP_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_last_grant;
    logic [2:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_op;
    logic       r_rsp_id;
    logic [3:0] r_rsp_result;
    logic       r_rsp_err;
    logic [7:0] r_op_count;
    logic [7:0] r_timer;

    logic       w_any_valid;
    logic       w_grant;
    logic       w_handshake;
    logic       w_rsp_accept;
    logic       w_drop;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        w_next_state = r_state;
        w_any_valid  = i_req0_valid | i_req1_valid;
        w_grant      = (i_req0_valid & i_req1_valid) ? ~r_last_grant : i_req1_valid;
        w_handshake  = 1'b0;
        w_rsp_accept = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_handshake  = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: w_next_state = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_accept = 1'b1;
                    w_next_state = IDLE;
                end else if (r_timer == TIMER_LAST) begin
                    w_drop       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_req0_ready = w_handshake & ~w_grant;
    assign o_req1_ready = w_handshake & w_grant;
    assign o_rsp_valid  = (r_state == RESP);
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_err    = r_rsp_err;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_op     = r_alu_op;
    assign o_drop_pulse = w_drop;
    assign o_op_count   = r_op_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
            r_timer      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_handshake) begin
                r_alu_a      <= w_grant ? i_req1_a  : i_req0_a;
                r_alu_b      <= w_grant ? i_req1_b  : i_req0_b;
                r_alu_op     <= w_grant ? i_req1_op : i_req0_op;
                r_last_grant <= w_grant;
            end
            // The last grant doubles as the owner id of the in-flight operation.
            if (r_state == EXEC) begin
                r_rsp_result <= i_alu_result;
                r_rsp_err    <= (r_alu_op > 3'b100);
                r_rsp_id     <= r_last_grant;
                r_timer      <= '0;
            end
            if (r_state == RESP) begin
                if (w_rsp_accept) begin
                    if (r_op_count != 8'hFF) begin
                        r_op_count <= r_op_count + 8'd1;
                    end
                end else begin
                    r_timer <= r_timer + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_alu_share_ctrl;
    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1, rspReady;
    logic [2:0] a0, op0, a1, op1;
    logic [3:0] b0, b1;
    logic       rdy0, rdy1, rspValid, rspId, rspErr, drop;
    logic [3:0] rspResult, aluResult, aluB;
    logic [2:0] aluA, aluOp;
    logic [7:0] opCount;

    int totalChecks = 0;
    int badChecks   = 0;
    bit checkEn     = 1'b0;

    // Reference model: phase 0 idle, 1 operation executing, 2+ response waiting.
    int         mPhase = 0;
    int         mLast  = 1;
    int         mCount = 0;
    logic [2:0] mA = '0, mOp = '0;
    logic [3:0] mB = '0;
    int         g;

    alu_share_ctrl #(.RSP_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_op(op0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_op(op1),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_id(rspId),
        .o_rsp_result(rspResult), .o_rsp_err(rspErr),
        .o_alu_a(aluA), .o_alu_b(aluB), .o_alu_op(aluOp), .i_alu_result(aluResult),
        .o_drop_pulse(drop), .o_op_count(opCount)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] aluFn(input logic [2:0] a, input logic [3:0] b, input logic [2:0] op);
        int ai = int'(a);
        int bi = int'(b);
        case (op)
            3'd0:    return 4'((ai + bi) % 16);
            3'd1:    return 4'((ai - bi + 16) % 16);
            3'd2:    return 4'(ai & bi);
            3'd3:    return 4'(ai | bi);
            3'd4:    return (ai < bi) ? 4'd1 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    always_comb aluResult = aluFn(aluA, aluB, aluOp);

    function automatic int expGrant();
        if (v0 && v1) return 1 - mLast;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mPhase = 0; mLast = 1; mCount = 0; mA = '0; mB = '0; mOp = '0;
        end else if (mPhase == 0) begin
            g = expGrant();
            if (g >= 0) begin
                mA = (g == 1) ? a1 : a0;
                mB = (g == 1) ? b1 : b0;
                mOp = (g == 1) ? op1 : op0;
                mLast = g;
                mPhase = 1;
            end
        end else if (mPhase == 1) begin
            mPhase = 2;
        end else if (rspReady) begin
            mCount = (mCount < 255) ? mCount + 1 : 255;
            mPhase = 0;
        end else if (mPhase - 2 == TO - 1) begin
            mPhase = 0;
        end else begin
            mPhase = mPhase + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, then compares every output with the model.
    task automatic applyStimulus(input logic nv0, input logic [2:0] na0, input logic [3:0] nb0, input logic [2:0] nop0,
                                 input logic nv1, input logic [2:0] na1, input logic [3:0] nb1, input logic [2:0] nop1,
                                 input logic nrdy, input logic nrst);
        int eg;
        @(negedge clk);
        v0 = nv0; a0 = na0; b0 = nb0; op0 = nop0;
        v1 = nv1; a1 = na1; b1 = nb1; op1 = nop1;
        rspReady = nrdy; rst = nrst;
        #1;
        if (checkEn) begin
            eg = expGrant();
            checkOutput("req0_ready", 32'(rdy0), 32'(mPhase == 0 && eg == 0));
            checkOutput("req1_ready", 32'(rdy1), 32'(mPhase == 0 && eg == 1));
            checkOutput("ready_onehot", 32'(rdy0 & rdy1), 32'd0);
            checkOutput("rsp_valid", 32'(rspValid), 32'(mPhase >= 2));
            checkOutput("drop_pulse", 32'(drop), 32'(mPhase >= 2 && !nrdy && (mPhase - 2 == TO - 1)));
            checkOutput("alu_a", 32'(aluA), 32'(mA));
            checkOutput("alu_b", 32'(aluB), 32'(mB));
            checkOutput("alu_op", 32'(aluOp), 32'(mOp));
            checkOutput("op_count", 32'(opCount), 32'(mCount));
            if (mPhase >= 2) begin
                checkOutput("rsp_id", 32'(rspId), 32'(mLast));
                checkOutput("rsp_result", 32'(rspResult), 32'(aluFn(mA, mB, mOp)));
                checkOutput("rsp_err", 32'(rspErr), 32'(mOp > 3'd4));
            end
        end
    endtask

    task automatic idleCycle(input logic nrdy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, nrdy, 0);
    endtask

    task automatic doOp(input int who, input logic [2:0] a, input logic [3:0] b, input logic [2:0] op,
                        output logic gotReady, output logic gotId, output logic [3:0] gotRes, output logic gotErr);
        if (who == 0) applyStimulus(1, a, b, op, 0, 0, 0, 0, 1, 0);
        else          applyStimulus(0, 0, 0, 0, 1, a, b, op, 1, 0);
        gotReady = (who == 0) ? rdy0 : rdy1;
        idleCycle(1);
        idleCycle(1);
        gotId = rspId; gotRes = rspResult; gotErr = rspErr;
    endtask

    initial begin
        int grants[$];
        logic gr, gi, ge;
        logic [3:0] gres;
        int countBefore;

        rst = 1'b1; rspReady = 1'b0;
        v0 = 0; a0 = 0; b0 = 0; op0 = 0; v1 = 0; a1 = 0; b1 = 0; op1 = 0;
        repeat (2) @(posedge clk);
        checkEn = 1'b1;

        // Reset state
        idleCycle(0);
        checkOutput("rst_op_count", 32'(opCount), 32'd0);
        checkOutput("rst_alu_a", 32'(aluA), 32'd0);
        checkOutput("rst_rsp_result", 32'(rspResult), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);

        // Contention fairness: both held valid for six operations
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1, 3'd1, 4'd2, 3'd0, 1, 3'd3, 4'd4, 3'd1, 1, 0);
            if (rdy0) grants.push_back(0);
            if (rdy1) grants.push_back(1);
        end
        checkOutput("grant_count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < grants.size() && k < 6; k++)
            checkOutput("grant_order", 32'(grants[k]), 32'(k % 2));

        // Basic ADD, then SUB and SLT with wrap from requester 1
        doOp(0, 3'd3, 4'd5, 3'd0, gr, gi, gres, ge);
        checkOutput("add_ready", 32'(gr), 32'd1);
        checkOutput("add_id", 32'(gi), 32'd0);
        checkOutput("add_result", 32'(gres), 32'h8);
        checkOutput("add_err", 32'(ge), 32'd0);
        idleCycle(0);
        checkOutput("add_count", 32'(opCount), 32'd7);
        doOp(1, 3'd2, 4'd5, 3'd1, gr, gi, gres, ge);
        checkOutput("sub_result", 32'(gres), 32'hD);
        checkOutput("sub_id", 32'(gi), 32'd1);
        doOp(1, 3'd2, 4'd5, 3'd4, gr, gi, gres, ge);
        checkOutput("slt_result", 32'(gres), 32'h1);
        checkOutput("slt_id", 32'(gi), 32'd1);

        // Saturation of the completed-operation counter
        for (int i = 0; i < 300 && mCount < 255; i++)
            doOp(int'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 3'($urandom), gr, gi, gres, ge);
        idleCycle(0);
        checkOutput("count_sat", 32'(opCount), 32'd255);
        doOp(0, 3'd1, 4'd1, 3'd0, gr, gi, gres, ge);
        idleCycle(0);
        checkOutput("count_hold", 32'(opCount), 32'd255);

        // Backpressure: ready withheld until the last cycle before timeout
        applyStimulus(1, 3'd1, 4'd2, 3'd0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 3'd1, 4'd2, 3'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) begin
            applyStimulus(1, 3'd1, 4'd2, 3'd0, 0, 0, 0, 0, 0, 0);
            checkOutput("bp_valid", 32'(rspValid), 32'd1);
            checkOutput("bp_result", 32'(rspResult), 32'h3);
            checkOutput("bp_no_ready", 32'(rdy0 | rdy1), 32'd0);
        end
        applyStimulus(1, 3'd1, 4'd2, 3'd0, 0, 0, 0, 0, 1, 0);
        checkOutput("bp_ready_wins", 32'(drop), 32'd0);
        applyStimulus(1, 3'd6, 4'd1, 3'd2, 0, 0, 0, 0, 1, 0);
        checkOutput("bp_idle_valid", 32'(rspValid), 32'd0);
        checkOutput("bp_next_accept", 32'(rdy0), 32'd1);
        idleCycle(1);
        idleCycle(1);

        // Timeout with rsp_ready stuck low
        countBefore = mCount;
        applyStimulus(0, 0, 0, 0, 1, 3'd7, 4'd9, 3'd3, 0, 0);
        idleCycle(0);
        for (int i = 1; i <= TO; i++) begin
            idleCycle(0);
            checkOutput("to_valid", 32'(rspValid), 32'd1);
            checkOutput("to_drop", 32'(drop), 32'(i == TO));
        end
        applyStimulus(1, 3'd2, 4'd2, 3'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("to_idle", 32'(rspValid), 32'd0);
        checkOutput("to_count", 32'(opCount), 32'(countBefore));
        checkOutput("to_next_accept", 32'(rdy0), 32'd1);
        idleCycle(1);
        idleCycle(1);

        // Undefined opcode, then reset during the response
        applyStimulus(1, 3'd5, 4'd3, 3'd7, 0, 0, 0, 0, 0, 0);
        idleCycle(0);
        idleCycle(0);
        checkOutput("undef_result", 32'(rspResult), 32'h0);
        checkOutput("undef_err", 32'(rspErr), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idleCycle(0);
        checkOutput("rst_resp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_resp_drop", 32'(drop), 32'd0);
        checkOutput("rst_resp_err", 32'(rspErr), 32'd0);
        checkOutput("rst_resp_alu_op", 32'(aluOp), 32'd0);
        checkOutput("rst_resp_count", 32'(opCount), 32'd0);

        // Randomized traffic, including occasional resets and long stalls
        for (int i = 0; i < 800; i++) begin
            applyStimulus(logic'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 3'($urandom),
                          logic'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 3'($urandom),
                          logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
